// File: rtl/uart_rx_cfg_if.sv
// Receiver-side signal bundle: serial line in, received word and status out.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 data_in;
    logic [DATA_BITS-1:0] databyte;
    logic                 data_recieved;
    logic                 parity_err;
    logic                 framing_err;

    // Receiver drives the word and status, consumes the serial line.
    modport master (
        input  data_in,
        output databyte,
        output data_recieved,
        output parity_err,
        output framing_err
    );

    // Line driver / downstream consumer.
    modport slave (
        output data_in,
        input  databyte,
        input  data_recieved,
        input  parity_err,
        input  framing_err
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, optional parity,
// 1 or 2 stop bits, mid-bit sampling with parity/framing error reporting.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_cfg_if.master bus
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned HALF_CNT = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned LAST_CNT = CLKS_PER_BIT - 1;

    // Reject configurations the datapath cannot represent.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks
            $error("uart_rx_cfg: CLKS_PER_BIT must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_cfg: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
        if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_par
            $error("uart_rx_cfg: PARITY_EN and PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_HIGH
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_mis;
    logic                 r_stop_err;
    logic [DATA_BITS-1:0] r_databyte;
    logic                 r_data_recieved;
    logic                 r_parity_err;
    logic                 r_framing_err;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_mis_nxt;
    logic                 w_stop_err_nxt;
    logic [DATA_BITS-1:0] w_databyte_nxt;
    logic                 w_data_recieved_nxt;
    logic                 w_parity_err_nxt;
    logic                 w_framing_err_nxt;
    logic                 w_stop_err_cur;
    logic                 w_cnt_half;
    logic                 w_cnt_last;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s     = r_sync2;
    assign w_cnt_half = (r_cnt == CNT_W'(HALF_CNT));
    assign w_cnt_last = (r_cnt == CNT_W'(LAST_CNT));

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_shift         <= '0;
            r_par_mis       <= 1'b0;
            r_stop_err      <= 1'b0;
            r_databyte      <= '0;
            r_data_recieved <= 1'b0;
            r_parity_err    <= 1'b0;
            r_framing_err   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_idx           <= w_idx_nxt;
            r_shift         <= w_shift_nxt;
            r_par_mis       <= w_par_mis_nxt;
            r_stop_err      <= w_stop_err_nxt;
            r_databyte      <= w_databyte_nxt;
            r_data_recieved <= w_data_recieved_nxt;
            r_parity_err    <= w_parity_err_nxt;
            r_framing_err   <= w_framing_err_nxt;
        end
    end

    // Frame sequencing; results are loaded on the edge entering DONE so the
    // strobe is high for the single DONE cycle.
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_idx_nxt           = r_idx;
        w_shift_nxt         = r_shift;
        w_par_mis_nxt       = r_par_mis;
        w_stop_err_nxt      = r_stop_err;
        w_databyte_nxt      = r_databyte;
        w_data_recieved_nxt = 1'b0;
        w_parity_err_nxt    = r_parity_err;
        w_framing_err_nxt   = r_framing_err;
        w_stop_err_cur      = r_stop_err | ~w_rx_s;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt    = S_START;
                    w_par_mis_nxt  = 1'b0;
                    w_stop_err_nxt = 1'b0;
                end
            end

            S_START: begin
                if (w_cnt_half) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    // LSB arrives first; after DATA_BITS shifts it sits at bit 0.
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (w_cnt_last) begin
                    w_cnt_nxt     = '0;
                    // Total XOR must be 0 for even, 1 for odd.
                    w_par_mis_nxt = (^r_shift) ^ w_rx_s ^ 1'(PARITY_ODD);
                    w_state_nxt   = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt      = '0;
                    w_stop_err_nxt = w_stop_err_cur;
                    if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                        w_idx_nxt           = '0;
                        w_state_nxt         = S_DONE;
                        w_databyte_nxt      = r_shift;
                        w_parity_err_nxt    = (PARITY_EN != 0) ? r_par_mis : 1'b0;
                        w_framing_err_nxt   = w_stop_err_cur;
                        w_data_recieved_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                // A low stop bit may be a break; wait for the line to recover.
                w_state_nxt = r_stop_err ? S_WAIT_HIGH : S_IDLE;
            end

            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.databyte      = r_databyte;
    assign bus.data_recieved = r_data_recieved;
    assign bus.parity_err    = r_parity_err;
    assign bus.framing_err   = r_framing_err;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four configurations share clock and reset,
// each with its own serial line.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 8;

    logic clk;
    logic rst_n;
    logic line [4];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int last_start = 0;
    int cnt0 = 0, cnt1 = 0, cnt2 = 0, cnt3 = 0;
    int stb_cyc0 = 0;
    logic [4:0] q3 [$];

    uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) bus2 ();
    uart_rx_cfg_if #(.DATA_BITS(5)) bus3 ();

    assign bus0.data_in = line[0];
    assign bus1.data_in = line[1];
    assign bus2.data_in = line[2];
    assign bus3.data_in = line[3];

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus0.data_recieved === 1'b1) begin
            cnt0++;
            stb_cyc0 = cyc;
        end
        if (bus1.data_recieved === 1'b1) cnt1++;
        if (bus2.data_recieved === 1'b1) cnt2++;
        if (bus3.data_recieved === 1'b1) begin
            cnt3++;
            q3.push_back(bus3.databyte);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives len bits LSB first, CPB cycles each; caller is at posedge+1.
    task automatic send_raw(input int idx, input logic [15:0] f, input int len);
        last_start = cyc;
        for (int b = 0; b < len; b++) begin
            line[idx] = f[4'(b)];
            idle(CPB);
        end
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input int nd,
                              input bit pen, input bit pbit, input int ns, input bit last_stop);
        logic [15:0] f;
        int n;
        f = '0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            f[4'(n)] = d[4'(i)];
            n++;
        end
        if (pen) begin
            f[4'(n)] = pbit;
            n++;
        end
        for (int s = 0; s < ns; s++) begin
            f[4'(n)] = (s == ns - 1) ? last_stop : 1'b1;
            n++;
        end
        send_raw(idx, f, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) line[i] = 1'b1;
        idle(4);
        check_eq("rst_databyte", 32'(bus0.databyte), 32'h0);
        check_eq("rst_strobe", 32'(bus0.data_recieved), 32'h0);
        check_eq("rst_parity_err", 32'(bus0.parity_err), 32'h0);
        check_eq("rst_framing_err", 32'(bus0.framing_err), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // 8N1 0xA5; strobe at 2 (sync) + 1 + 3 (half) + 1 + 9*8 = 79 cycles after start edge.
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        check_eq("a5_count", 32'(cnt0), 32'd1);
        check_eq("a5_databyte", 32'(bus0.databyte), 32'hA5);
        check_eq("a5_parity_err", 32'(bus0.parity_err), 32'h0);
        check_eq("a5_framing_err", 32'(bus0.framing_err), 32'h0);
        check_eq("a5_latency", 32'(stb_cyc0 - last_start), 32'd79);

        // 3-cycle glitch is rejected at the start-bit mid sample.
        line[0] = 1'b0;
        idle(3);
        line[0] = 1'b1;
        idle(20);
        check_eq("glitch_count", 32'(cnt0), 32'd1);
        check_eq("glitch_held_byte", 32'(bus0.databyte), 32'hA5);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        check_eq("3c_count", 32'(cnt0), 32'd2);
        check_eq("3c_databyte", 32'(bus0.databyte), 32'h3C);

        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1);
        idle(4);
        check_eq("par_ok_count", 32'(cnt1), 32'd1);
        check_eq("par_ok_databyte", 32'(bus1.databyte), 32'h07);
        check_eq("par_ok_err", 32'(bus1.parity_err), 32'h0);
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1);
        idle(4);
        check_eq("par_bad_count", 32'(cnt1), 32'd2);
        check_eq("par_bad_err", 32'(bus1.parity_err), 32'h1);
        check_eq("par_bad_databyte", 32'(bus1.databyte), 32'h07);
        check_eq("par_bad_framing", 32'(bus1.framing_err), 32'h0);

        // Two stop bits, second low, then line stuck low.
        send_frame(2, 9'h055, 8, 1'b0, 1'b0, 2, 1'b0);
        idle(50);
        check_eq("brk_count", 32'(cnt2), 32'd1);
        check_eq("brk_framing_err", 32'(bus2.framing_err), 32'h1);
        check_eq("brk_databyte", 32'(bus2.databyte), 32'h55);
        line[2] = 1'b1;
        idle(20);
        check_eq("brk_recover_count", 32'(cnt2), 32'd1);
        send_frame(2, 9'h0A3, 8, 1'b0, 1'b0, 2, 1'b1);
        idle(4);
        check_eq("a3_count", 32'(cnt2), 32'd2);
        check_eq("a3_framing_err", 32'(bus2.framing_err), 32'h0);
        check_eq("a3_databyte", 32'(bus2.databyte), 32'hA3);

        // 5 data bits, back-to-back frames.
        send_frame(3, 9'h01B, 5, 1'b0, 1'b0, 1, 1'b1);
        send_frame(3, 9'h004, 5, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        check_eq("b2b_count", 32'(cnt3), 32'd2);
        check_eq("b2b_first", (q3.size() > 0) ? 32'(q3[0]) : 32'hDEAD, 32'h1B);
        check_eq("b2b_second", (q3.size() > 1) ? 32'(q3[1]) : 32'hDEAD, 32'h04);

        // Reset during data bit 4 of 0xF0.
        send_raw(0, 16'h0000, 5);
        line[0] = 1'b1;
        idle(3);
        rst_n = 1'b0;
        idle(1);
        check_eq("mid_rst_databyte", 32'(bus0.databyte), 32'h0);
        check_eq("mid_rst_strobe", 32'(bus0.data_recieved), 32'h0);
        check_eq("mid_rst_framing", 32'(bus0.framing_err), 32'h0);
        idle(1);
        rst_n = 1'b1;
        idle(60);
        check_eq("post_rst_count", 32'(cnt0), 32'd2);
        check_eq("post_rst_databyte", 32'(bus0.databyte), 32'h0);
        send_frame(0, 9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        check_eq("f0_count", 32'(cnt0), 32'd3);
        check_eq("f0_databyte", 32'(bus0.databyte), 32'hF0);
        check_eq("f0_framing_err", 32'(bus0.framing_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
